// File: rtl/cpu_pkg.sv
// Shared types and constants for the bit-serial SPI CPU core.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CMD   = 3'd1,
      S_ADDR  = 3'd2,
      S_DATA  = 3'd3,
      S_EXEC  = 3'd4,
      S_MCMD  = 3'd5,
      S_MADDR = 3'd6,
      S_MDATA = 3'd7
   } state_e;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   localparam logic [1:0] OP_ADDI  = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [1:0] OP_JZ    = 2'b11;

   // Serial phase lengths in clock cycles.
   localparam int unsigned CMD_LEN  = 8;
   localparam int unsigned ADDR_LEN = 24;
   localparam int unsigned DATA_LEN = 8;

   // The shifter sends its LSB first, so values destined to go out MSB first
   // are loaded bit-reversed.
   function automatic logic [23:0] rev24(input logic [23:0] v);
      logic [23:0] r;
      for (int i = 0; i < 24; i++) r[i] = v[23-i];
      return r;
   endfunction

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

endpackage

// File: rtl/cpu_spi_seq.sv
// Bit counter shared by every serial phase; flags the last cycle of the
// current phase so the core knows when to advance.
module cpu_spi_seq
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] state,
   output logic       last
);

   logic [4:0] bitcnt_q, bitcnt_d;
   logic [4:0] len_m1;

   // Phase length for the current state; single-cycle states count as length 1.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      len_m1 = 5'd0;
      unique case (state)
         S_CMD,  S_MCMD:  len_m1 = 5'(CMD_LEN - 1);
         S_ADDR, S_MADDR: len_m1 = 5'(ADDR_LEN - 1);
         S_DATA, S_MDATA: len_m1 = 5'(DATA_LEN - 1);
         default:         len_m1 = 5'd0;
      endcase
      last     = (bitcnt_q == len_m1);
      bitcnt_d = last ? 5'd0 : bitcnt_q + 5'd1;
   end

   // Bit counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (!rst_n) bitcnt_q <= 5'd0;
      else        bitcnt_q <= bitcnt_d;
   end

endmodule

// File: rtl/cpu.sv
// Bit-serial CPU: fetches each 8-bit instruction with a fresh SPI ROM READ,
// executes it, and reaches data through an SPI SRAM for LOAD/STORE.
module cpu
   import cpu_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic miso_rom,
   input  logic miso_ram,
   output logic mosi_rom,
   output logic mosi_ram,
   output logic cs_rom_n,
   output logic cs_ram_n,
   output logic hold_rom_n
);

   state_e      state, state_d;
   logic [23:0] accumulator, accumulator_d;
   logic [23:0] pc_q, pc_d;
   logic [7:0]  a_q, a_d;
   logic [7:0]  ir_q, ir_d;

   logic        last;
   logic [1:0]  opcode;
   logic [5:0]  imm;
   logic [23:0] imm_sext;
   logic [7:0]  mem_cmd;
   logic        rom_sel, ram_sel;

   assign opcode   = ir_q[7:6];
   assign imm      = ir_q[5:0];
   assign imm_sext = {{18{imm[5]}}, imm};
   assign mem_cmd  = (opcode == OP_STORE) ? CMD_WRITE : CMD_READ;

   cpu_spi_seq u_spi_seq (
      .clk   (clk),
      .rst_n (rst_n),
      .state (state),
      .last  (last)
   );

   // Next-state, shifter and architectural register updates.
   always_comb begin
      state_d       = state;
      accumulator_d = {1'b0, accumulator[23:1]};
      pc_d          = pc_q;
      a_d           = a_q;
      ir_d          = ir_q;
      unique case (state)
         S_IDLE: begin
            // Preload the command so the shifter LSB drives MOSI in every phase.
            accumulator_d = {16'b0, rev8(CMD_READ)};
            state_d       = S_CMD;
         end
         S_CMD: if (last) begin
            accumulator_d = rev24(pc_q);
            state_d       = S_ADDR;
         end
         S_ADDR: if (last) state_d = S_DATA;
         S_DATA: begin
            ir_d = {ir_q[6:0], miso_rom};
            if (last) state_d = S_EXEC;
         end
         S_EXEC: begin
            pc_d          = pc_q + 24'd1;
            accumulator_d = {16'b0, rev8(mem_cmd)};
            state_d       = S_IDLE;
            unique case (opcode)
               OP_ADDI:  a_d = a_q + {2'b00, imm};
               OP_LOAD,
               OP_STORE: state_d = S_MCMD;
               OP_JZ:    if (a_q == 8'd0) pc_d = pc_q + imm_sext;
               default:  state_d = S_IDLE;
            endcase
         end
         S_MCMD: if (last) begin
            accumulator_d = rev24({18'b0, imm});
            state_d       = S_MADDR;
         end
         S_MADDR: if (last) begin
            accumulator_d = (opcode == OP_STORE) ? {16'b0, rev8(a_q)} : 24'd0;
            state_d       = S_MDATA;
         end
         S_MDATA: begin
            if (opcode == OP_LOAD) a_d = {a_q[6:0], miso_ram};
            if (last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Chip selects and MOSI decode directly from registered state.
   always_comb begin
      rom_sel    = (state == S_CMD)  || (state == S_ADDR)  || (state == S_DATA);
      ram_sel    = (state == S_MCMD) || (state == S_MADDR) || (state == S_MDATA);
      cs_rom_n   = ~rom_sel;
      cs_ram_n   = ~ram_sel;
      mosi_rom   = rom_sel & accumulator[0];
      mosi_ram   = ram_sel & accumulator[0];
      hold_rom_n = 1'b1;
   end

   // State and datapath registers; reset aborts any transaction at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         accumulator <= 24'd0;
         pc_q        <= 24'd0;
         a_q         <= 8'd0;
         ir_q        <= 8'd0;
      end else begin
         state       <= state_d;
         accumulator <= accumulator_d;
         pc_q        <= pc_d;
         a_q         <= a_d;
         ir_q        <= ir_d;
      end
   end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for the bit-serial SPI CPU: drives ROM/RAM MISO bit by bit
// and checks every serial cycle against hand-derived command/address/data bits.
module tb_cpu;

   logic clk = 1'b0;
   logic rst_n;
   logic miso_rom, miso_ram;
   logic mosi_rom, mosi_ram, cs_rom_n, cs_ram_n, hold_rom_n;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cpu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .miso_rom   (miso_rom),
      .miso_ram   (miso_ram),
      .mosi_rom   (mosi_rom),
      .mosi_ram   (mosi_ram),
      .cs_rom_n   (cs_rom_n),
      .cs_ram_n   (cs_ram_n),
      .hold_rom_n (hold_rom_n)
   );

   // Walks one IDLE cycle plus a 40-cycle ROM READ at addr returning instr,
   // then the EXEC cycle. Entered and left at posedge+1.
   task automatic run_fetch(input logic [23:0] addr, input logic [7:0] instr, input string tag);
      logic [7:0] cmd, exp, obs;
      logic [2:0] st;
      logic       bit_v;
      cmd = 8'h03;
      for (int k = 0; k <= 40; k++) begin
         bit_v = 1'b0;
         st    = 3'd0;
         if (k >= 1 && k <= 8) begin
            st = 3'd1; bit_v = cmd[8-k];
         end else if (k >= 9 && k <= 32) begin
            st = 3'd2; bit_v = addr[32-k];
         end else if (k >= 33) begin
            st = 3'd3;
         end
         miso_rom = (k >= 33) ? instr[40-k] : 1'b0;
         exp = {st, (k == 0), 1'b1, bit_v, 1'b0, 1'b1};
         obs = {dut.state, cs_rom_n, cs_ram_n, mosi_rom, mosi_ram, hold_rom_n};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL fetch %s cycle %0d: {state,csr,csm,mr,mm,hold} got %b want %b", tag, k, obs, exp);
         end
         if (st == 3'd2) begin
            vectors++;
            if (dut.accumulator[0] !== bit_v) begin
               miscompares++;
               $display("FAIL fetch %s acc0 cycle %0d: got %b want %b", tag, k, dut.accumulator[0], bit_v);
            end
         end
         @(posedge clk); #1;
      end
      miso_rom = 1'b0;
      exp = {3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      obs = {dut.state, cs_rom_n, cs_ram_n, mosi_rom, mosi_ram, hold_rom_n};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL exec %s: got %b want %b", tag, obs, exp);
      end
      @(posedge clk); #1;
   endtask

   // Walks a 40-cycle RAM access starting in the MCMD cycle; ends in IDLE.
   task automatic run_mem(input logic is_store, input logic [5:0] addr6,
                          input logic [7:0] wdata, input logic [7:0] rdata, input string tag);
      logic [7:0]  cmd, exp, obs;
      logic [23:0] addr;
      logic [2:0]  st;
      logic        bit_v;
      cmd  = is_store ? 8'h02 : 8'h03;
      addr = {18'b0, addr6};
      for (int k = 0; k < 40; k++) begin
         if (k < 8) begin
            st = 3'd5; bit_v = cmd[7-k];
         end else if (k < 32) begin
            st = 3'd6; bit_v = addr[31-k];
         end else begin
            st = 3'd7; bit_v = is_store ? wdata[39-k] : 1'b0;
         end
         miso_ram = (k >= 32) ? rdata[39-k] : 1'b0;
         exp = {st, 1'b1, 1'b0, 1'b0, bit_v, 1'b1};
         obs = {dut.state, cs_rom_n, cs_ram_n, mosi_rom, mosi_ram, hold_rom_n};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL mem %s cycle %0d: {state,csr,csm,mr,mm,hold} got %b want %b", tag, k, obs, exp);
         end
         @(posedge clk); #1;
      end
      miso_ram = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] obs;
      rst_n = 1'b0; miso_rom = 1'b0; miso_ram = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      obs = {dut.state, cs_rom_n, cs_ram_n, mosi_rom, mosi_ram, hold_rom_n};
      vectors++;
      if (obs !== 8'b000_11001) begin
         miscompares++;
         $display("FAIL reset outputs: got %b want %b", obs, 8'b000_11001);
      end
      vectors++;
      if (dut.accumulator !== 24'd0) begin
         miscompares++;
         $display("FAIL reset accumulator: got %h want 000000", dut.accumulator);
      end
      rst_n = 1'b1;
   endtask

   // ADDI 0 at pc 0; the following fetch must target 0x000001.
   task automatic test_first_fetch();
      run_fetch(24'h000000, 8'h00, "first");
   endtask

   // 5+5 = 0x0A, observed through a STORE to address 3.
   task automatic test_addi();
      run_fetch(24'h000001, 8'h05, "addi5a");
      run_fetch(24'h000002, 8'h05, "addi5b");
      run_fetch(24'h000003, 8'h83, "store3");
      run_mem(1'b1, 6'd3, 8'h0A, 8'hFF, "store3");
   endtask

   // LOAD 0xA5, JZ not taken; LOAD 0x00, JZ -2 taken back to pc 5.
   task automatic test_load_jz();
      run_fetch(24'h000004, 8'h41, "load1");
      run_mem(1'b0, 6'd1, 8'h00, 8'hA5, "load1");
      run_fetch(24'h000005, 8'hC4, "jz_nt");
      run_fetch(24'h000006, 8'h42, "load2");
      run_mem(1'b0, 6'd2, 8'h00, 8'h00, "load2");
      run_fetch(24'h000007, 8'hFE, "jz_t");
   endtask

   // Five ADDI 63 from 0 wrap to 0x3B; +0x1F gives 0x5A; both stored.
   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) run_fetch(24'(5 + i), 8'h3F, "addi63");
      run_fetch(24'h00000A, 8'h82, "store2");
      run_mem(1'b1, 6'd2, 8'h3B, 8'h00, "store2");
      run_fetch(24'h00000B, 8'h1F, "addi31");
      run_fetch(24'h00000C, 8'h81, "store1");
      run_mem(1'b1, 6'd1, 8'h5A, 8'h00, "store1");
   endtask

   task automatic test_reset_mid_addr();
      logic [7:0] obs;
      repeat (15) @(posedge clk);
      #1;
      vectors++;
      if (dut.state !== 3'd2) begin
         miscompares++;
         $display("FAIL midreset pre-state: got %0d want 2", dut.state);
      end
      rst_n = 1'b0;
      #1;
      obs = {dut.state, cs_rom_n, cs_ram_n, mosi_rom, mosi_ram, hold_rom_n};
      vectors++;
      if (obs !== 8'b000_11001) begin
         miscompares++;
         $display("FAIL midreset outputs: got %b want %b", obs, 8'b000_11001);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_fetch(24'h000000, 8'hFE, "post_rst");
   endtask

   // JZ -2 from pc 0 with a=0 lands on 0xFFFFFE; two more steps wrap to 0.
   task automatic test_pc_wrap();
      run_fetch(24'hFFFFFE, 8'h00, "wrap_fe");
      run_fetch(24'hFFFFFF, 8'h3F, "wrap_ff");
      run_fetch(24'h000000, 8'h00, "wrap_00");
      run_fetch(24'h000001, 8'h00, "wrap_01");
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_addi();
      test_load_jz();
      test_back_to_back();
      test_reset_mid_addr();
      test_pc_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
